puf_race_sampler: RTL and testbench
===================================

Name: puf_race_sampler

Overview:
- Control and capture stage wrapped around the PUF switch chain.
- Drives the launch edge into the first demux stage and holds the challenge on every stage select.
- Samples which chain output arrives first, repeats the race EVALS times, and majority-votes the result into one response bit.
- Sits between the challenge source (host/LFSR) and the response register.

Parameters:
- CW, 64, challenge width = number of demux stages in the chain.
- EVALS, 15, races per challenge; must be odd, range 1..255.
- SETTLE, 4, cycles for select settling / chain discharge before and after each race; >=1.
- TIMEOUT, 255, max cycles waiting for an arrival before declaring a fault; >=1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  request; accepted only when busy=0.
- challenge  in  CW  challenge bits; captured on accepted start.
- race_top  in  1  top output of the last chain stage (already double-flop synchronized externally).
- race_bot  in  1  bottom output of the last chain stage (synchronized likewise).
- launch  out  1  data input driven into the first demux stage.
- sel  out  CW  registered challenge driving the stage selects.
- busy  out  1  high from start acceptance until the cycle resp_valid is asserted.
- resp  out  1  majority-voted response bit.
- resp_valid  out  1  one-cycle pulse; resp and ones are valid in that cycle.
- ones  out  8  count of races won by race_top.
- fault  out  1  a race timed out; sticky until the next accepted start.

Behaviour:
- Clock and reset: one clock, clk. Synchronous active-low reset rst_n, sampled on rising clk.
- Reset values:
  - launch=0, sel=0, busy=0, resp=0, resp_valid=0, ones=0, fault=0.
  - State returns to IDLE; internal counters clear.
  - Reset mid-operation aborts the current challenge; no resp_valid is produced for it.
- States:
  - IDLE: wait for start.
  - SETUP: hold sel, keep launch=0, count SETTLE cycles.
  - FIRE: launch=1.
  - WAIT: sample race_top/race_bot each cycle.
  - DISCHARGE: launch=0 for SETTLE cycles.
  - DONE: report the result.
- IDLE:
  - On start=1: sel<=challenge, ones<=0, race counter<=0, fault<=0, busy<=1, go to SETUP.
  - start while busy=1 is ignored; no queueing.
- SETUP -> FIRE after exactly SETTLE cycles.
  - SETUP is entered once per challenge.
  - Subsequent races enter FIRE directly from DISCHARGE.
- FIRE -> WAIT after one cycle. launch stays 1 through WAIT.
- WAIT, evaluated each cycle:
  - race_top=1, race_bot=0: top wins; ones increments.
  - race_bot=1, race_top=0: bottom wins; ones unchanged.
  - Both high in the same cycle: tie; counted as a bottom win; ones unchanged.
  - Any of the above ends the race and goes to DISCHARGE.
  - Neither high for TIMEOUT consecutive cycles: fault<=1; race counts as a bottom win; go to DISCHARGE.
- DISCHARGE:
  - Stays at least SETTLE cycles, and until race_top=0 and race_bot=0.
  - Lingers further while either input is stuck high; no timeout applies here.
  - Race counter increments on DISCHARGE entry.
  - Counter == EVALS at exit: go to DONE. Otherwise go to FIRE.
- DONE, one cycle:
  - resp <= (ones > EVALS/2), integer division.
  - resp_valid=1, busy<=0, then return to IDLE.
- Output holding:
  - resp and ones hold their values until the next accepted start (ones clears then).
  - sel holds its value until the next accepted start.
- ones width: 8 bits; never exceeds EVALS (<=255), so no wrap.
- Back-to-back operation: start asserted in the cycle after DONE is accepted (IDLE).
- Minimum latency, start to resp_valid, with immediate arrivals:
  - 1 + SETTLE + EVALS*(1 + 1 + SETTLE) + 1 cycles.
  - Default EVALS=15, SETTLE=4: 96 cycles.

Test Plan:
- Race model: top arrives 3 cycles after launch rises, bottom 5 cycles after; EVALS=15; start with challenge=64'hA5A5_0000_FFFF_1234 -> sel equals that value from the cycle after start; launch pulses exactly 15 times; resp_valid after 96+2*15 cycles with resp=1, ones=15, fault=0.
- Alternate the winner per race (top first on odd races, beginning with race 1) -> ones=8, resp=1. Then top wins only 7 of 15 -> ones=7, resp=0.
- Both race inputs rise in the same cycle on every race -> ones=0, resp=0, fault=0.
- race_bot stuck high after race 4 (never falls in DISCHARGE) -> FSM stays in DISCHARGE with launch=0; no resp_valid; then release -> completes normally.
- No arrivals at all -> fault=1 after TIMEOUT cycles of WAIT on the first race, still completes 15 races; resp=0, ones=0; the next start clears fault.
- rst_n low for one cycle mid-WAIT on race 7 -> next cycle all outputs 0, state IDLE; a start 1 cycle later begins a fresh sequence, with ones starting at 0.

Source files
------------

// File: rtl/puf_race_sampler.sv
// Launch/capture controller for a PUF switch-chain race: holds the challenge on
// the stage selects, fires EVALS races and majority-votes the winners into one bit.
module puf_race_sampler #(
   parameter int CW      = 64,
   parameter int EVALS   = 15,
   parameter int SETTLE  = 4,
   parameter int TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [CW-1:0] challenge,
   input  logic          race_top,
   input  logic          race_bot,
   output logic          launch,
   output logic [CW-1:0] sel,
   output logic          busy,
   output logic          resp,
   output logic          resp_valid,
   output logic [7:0]    ones,
   output logic          fault
);

   localparam int CNT_MAX = (SETTLE > TIMEOUT) ? SETTLE : TIMEOUT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [7:0]       EVALS_C      = 8'(EVALS);
   localparam logic [7:0]       HALF_C       = 8'(EVALS / 2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_FIRE,
      S_WAIT,
      S_DISCHARGE,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       race_cnt_q, race_cnt_d;
   logic             launch_q, launch_d;
   logic [CW-1:0]    sel_q, sel_d;
   logic             busy_q, busy_d;
   logic             resp_q, resp_d;
   logic             resp_valid_q, resp_valid_d;
   logic [7:0]       ones_q, ones_d;
   logic             fault_q, fault_d;
   logic             end_race;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      race_cnt_d   = race_cnt_q;
      launch_d     = launch_q;
      sel_d        = sel_q;
      busy_d       = busy_q;
      resp_d       = resp_q;
      resp_valid_d = 1'b0;
      ones_d       = ones_q;
      fault_d      = fault_q;
      end_race     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               sel_d      = challenge;
               ones_d     = '0;
               race_cnt_d = '0;
               fault_d    = 1'b0;
               busy_d     = 1'b1;
               cnt_d      = '0;
               state_d    = S_SETUP;
            end
         end

         S_SETUP: begin
            if (cnt_q == SETTLE_LAST) begin
               cnt_d    = '0;
               launch_d = 1'b1;
               state_d  = S_FIRE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         S_FIRE: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end

         S_WAIT: begin
            // A tie and a timeout both count as a bottom win.
            if (race_top || race_bot) begin
               if (race_top && !race_bot) begin
                  ones_d = ones_q + 8'd1;
               end
               end_race = 1'b1;
            end else if (cnt_q == TIMEOUT_LAST) begin
               fault_d  = 1'b1;
               end_race = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
            if (end_race) begin
               launch_d   = 1'b0;
               cnt_d      = '0;
               race_cnt_d = race_cnt_q + 8'd1;
               state_d    = S_DISCHARGE;
            end
         end

         S_DISCHARGE: begin
            // Count saturates so a stuck-high output can hold us here indefinitely.
            if (cnt_q != SETTLE_LAST) begin
               cnt_d = cnt_q + 1'b1;
            end else if (!race_top && !race_bot) begin
               cnt_d = '0;
               if (race_cnt_q == EVALS_C) begin
                  state_d = S_DONE;
               end else begin
                  launch_d = 1'b1;
                  state_d  = S_FIRE;
               end
            end
         end

         S_DONE: begin
            resp_d       = (ones_q > HALF_C);
            resp_valid_d = 1'b1;
            busy_d       = 1'b0;
            state_d      = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         race_cnt_q   <= '0;
         launch_q     <= 1'b0;
         sel_q        <= '0;
         busy_q       <= 1'b0;
         resp_q       <= 1'b0;
         resp_valid_q <= 1'b0;
         ones_q       <= '0;
         fault_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         race_cnt_q   <= race_cnt_d;
         launch_q     <= launch_d;
         sel_q        <= sel_d;
         busy_q       <= busy_d;
         resp_q       <= resp_d;
         resp_valid_q <= resp_valid_d;
         ones_q       <= ones_d;
         fault_q      <= fault_d;
      end
   end

   assign launch     = launch_q;
   assign sel        = sel_q;
   assign busy       = busy_q;
   assign resp       = resp_q;
   assign resp_valid = resp_valid_q;
   assign ones       = ones_q;
   assign fault      = fault_q;

endmodule

// File: tb/tb_puf_race_sampler.sv
// Bench for puf_race_sampler: a delay-table chain model drives the race inputs and
// a result/latency model, computed from the per-race delays, is checked every cycle.
module tb_puf_race_sampler;

   localparam int CW      = 64;
   localparam int EVALS   = 15;
   localparam int SETTLE  = 4;
   localparam int TIMEOUT = 255;
   localparam int NEVER   = 100000;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [CW-1:0] challenge = '0;
   logic          race_top, race_bot;
   logic          launch, busy, resp, resp_valid, fault;
   logic [CW-1:0] sel;
   logic [7:0]    ones;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Chain model state: cycles since launch rose and which race is running.
   int   since = 0;
   int   race_num = 0;
   int   dly_top[EVALS];
   int   dly_bot[EVALS];
   logic stuck_bot = 1'b0;

   // Scoreboard: expected {fault, resp, ones} per accepted challenge.
   logic [9:0]    exp_q[$];
   logic [9:0]    exp_e;
   logic          timing_on = 1'b0;
   int            start_cyc = 0;
   int            exp_done = 0;
   logic [CW-1:0] exp_sel = '0;

   puf_race_sampler #(
      .CW(CW), .EVALS(EVALS), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .challenge(challenge),
      .race_top(race_top),
      .race_bot(race_bot),
      .launch(launch),
      .sel(sel),
      .busy(busy),
      .resp(resp),
      .resp_valid(resp_valid),
      .ones(ones),
      .fault(fault)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!rst_n || (start && !busy)) begin
         since    <= 0;
         race_num <= 0;
      end else begin
         since <= launch ? since + 1 : 0;
         if (launch && since == 0) race_num <= race_num + 1;
      end
   end

   always_comb begin
      race_top = 1'b0;
      race_bot = stuck_bot;
      if (launch && since > 0 && race_num > 0 && race_num <= EVALS) begin
         if (since >= dly_top[race_num-1]) race_top = 1'b1;
         if (since >= dly_bot[race_num-1]) race_bot = 1'b1;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   always @(negedge clk) begin
      if (timing_on) begin
         check("busy", busy, (cyc > start_cyc && cyc < exp_done));
         check("resp_valid_time", resp_valid, (cyc == exp_done));
         if (cyc > start_cyc) check("sel", sel, exp_sel);
      end
      if (rst_n && resp_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_resp_valid", 1, 0);
         end else begin
            exp_e = exp_q.pop_front();
            check("fault", fault, exp_e[9]);
            check("resp", resp, exp_e[8]);
            check("ones", ones, exp_e[7:0]);
         end
      end
   end

   task automatic run_challenge(input logic [CW-1:0] ch, input logic timed, input int stuck_race,
                                output int lat, output int model_lat, output logic [7:0] got_ones,
                                output logic got_resp, output logic got_fault);
      int   n_top;
      logic any_to;
      int   w;
      int   bound;
      logic hit;
      n_top     = 0;
      any_to    = 1'b0;
      model_lat = 2 + SETTLE;
      for (int i = 0; i < EVALS; i++) begin
         w = (dly_top[i] < dly_bot[i]) ? dly_top[i] : dly_bot[i];
         if (w > TIMEOUT) begin
            any_to = 1'b1;
            w      = TIMEOUT;
         end else if (dly_top[i] < dly_bot[i]) begin
            n_top++;
         end
         model_lat += 1 + w + SETTLE;
      end
      exp_q.push_back({any_to, (n_top > EVALS / 2) ? 1'b1 : 1'b0, 8'(n_top)});

      exp_sel   = ch;
      start_cyc = cyc;
      exp_done  = cyc + model_lat;
      timing_on = timed;
      challenge = ch;
      start     = 1'b1;
      tick();
      start = 1'b0;
      check("fault_clear", fault, 0);
      check("ones_clear", ones, 0);

      if (stuck_race > 0) begin
         hit = 1'b0;
         for (int i = 0; i < 5000; i++) begin
            if (race_num == stuck_race && !launch) begin
               hit = 1'b1;
               break;
            end
            tick();
         end
         check("reach_stuck_race", hit, 1);
         stuck_bot = 1'b1;
         for (int i = 0; i < 20; i++) begin
            tick();
            check("stuck_launch", launch, 0);
            check("stuck_resp_valid", resp_valid, 0);
            check("stuck_busy", busy, 1);
         end
         stuck_bot = 1'b0;
      end

      bound = model_lat + 200;
      lat   = -1;
      for (int i = 0; i < bound; i++) begin
         if (resp_valid) begin
            lat = cyc - start_cyc;
            break;
         end
         tick();
      end
      if (lat < 0) check("resp_valid_timeout", 0, 1);
      got_ones  = ones;
      got_resp  = resp;
      got_fault = fault;
      check("launch_pulses", race_num, EVALS);
      tick();
      check("ones_hold", ones, got_ones);
      check("resp_hold", resp, got_resp);
      check("sel_hold", sel, ch);
      timing_on = 1'b0;
   endtask

   initial begin
      #1000000;
      errors++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      int         lat, mlat;
      logic [7:0] g_ones;
      logic       g_resp, g_fault;
      logic       hit;

      repeat (3) tick();
      check("rst_launch", launch, 0);
      check("rst_sel", sel, 0);
      check("rst_busy", busy, 0);
      check("rst_resp", resp, 0);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_ones", ones, 0);
      check("rst_fault", fault, 0);
      rst_n = 1'b1;
      tick();

      // Top at 3 cycles, bottom at 5: every race a top win.
      for (int i = 0; i < EVALS; i++) begin dly_top[i] = 3; dly_bot[i] = 5; end
      run_challenge(64'hA5A5_0000_FFFF_1234, 1'b1, 0, lat, mlat, g_ones, g_resp, g_fault);
      check("t1_model_lat", mlat, 126);
      check("t1_lat", lat, 126);
      check("t1_ones", g_ones, 15);
      check("t1_resp", g_resp, 1);
      check("t1_fault", g_fault, 0);

      // Top wins odd races starting at race 1.
      for (int i = 0; i < EVALS; i++) begin
         dly_top[i] = (i % 2 == 0) ? 2 : 4;
         dly_bot[i] = (i % 2 == 0) ? 4 : 2;
      end
      run_challenge(64'h0123_4567_89AB_CDEF, 1'b1, 0, lat, mlat, g_ones, g_resp, g_fault);
      check("t2_ones", g_ones, 8);
      check("t2_resp", g_resp, 1);

      // Top wins only the even races: 7 of 15.
      for (int i = 0; i < EVALS; i++) begin
         dly_top[i] = (i % 2 == 1) ? 2 : 4;
         dly_bot[i] = (i % 2 == 1) ? 4 : 2;
      end
      run_challenge(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0, lat, mlat, g_ones, g_resp, g_fault);
      check("t3_ones", g_ones, 7);
      check("t3_resp", g_resp, 0);

      // Simultaneous arrival every race.
      for (int i = 0; i < EVALS; i++) begin dly_top[i] = 2; dly_bot[i] = 2; end
      run_challenge(64'h8000_0000_0000_0001, 1'b1, 0, lat, mlat, g_ones, g_resp, g_fault);
      check("t4_ones", g_ones, 0);
      check("t4_resp", g_resp, 0);
      check("t4_fault", g_fault, 0);

      // Bottom output stuck high during discharge after race 4.
      for (int i = 0; i < EVALS; i++) begin dly_top[i] = 1; dly_bot[i] = 3; end
      run_challenge(64'h5555_AAAA_5555_AAAA, 1'b0, 4, lat, mlat, g_ones, g_resp, g_fault);
      check("t5_ones", g_ones, 15);
      check("t5_resp", g_resp, 1);
      check("t5_lat_stretched", (lat > mlat) ? 1 : 0, 1);

      // No arrivals at all: every race times out.
      for (int i = 0; i < EVALS; i++) begin dly_top[i] = NEVER; dly_bot[i] = NEVER; end
      run_challenge(64'h0000_0000_0000_0000, 1'b1, 0, lat, mlat, g_ones, g_resp, g_fault);
      check("t6_lat", lat, 3906);
      check("t6_ones", g_ones, 0);
      check("t6_resp", g_resp, 0);
      check("t6_fault", g_fault, 1);

      // Immediate arrivals: minimum latency, and fault cleared by the new start.
      for (int i = 0; i < EVALS; i++) begin dly_top[i] = 1; dly_bot[i] = 2; end
      run_challenge(64'hDEAD_BEEF_CAFE_F00D, 1'b1, 0, lat, mlat, g_ones, g_resp, g_fault);
      check("t7_lat", lat, 96);
      check("t7_fault", g_fault, 0);
      check("t7_ones", g_ones, 15);

      // Reset mid-WAIT on race 7, then a fresh challenge.
      for (int i = 0; i < EVALS; i++) begin
         dly_top[i] = (i % 3 == 0) ? 4 : 1;
         dly_bot[i] = (i % 3 == 0) ? 2 : 3;
      end
      dly_top[6] = 40;
      dly_bot[6] = 60;
      challenge = 64'h1111_2222_3333_4444;
      start = 1'b1;
      tick();
      start = 1'b0;
      hit = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         if (race_num == 7 && launch) begin
            hit = 1'b1;
            break;
         end
         tick();
      end
      check("reach_race7", hit, 1);
      repeat (5) tick();
      check("pre_rst_busy", busy, 1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("mid_rst_launch", launch, 0);
      check("mid_rst_sel", sel, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_resp", resp, 0);
      check("mid_rst_resp_valid", resp_valid, 0);
      check("mid_rst_ones", ones, 0);
      check("mid_rst_fault", fault, 0);
      tick();
      run_challenge(64'h9999_8888_7777_6666, 1'b1, 0, lat, mlat, g_ones, g_resp, g_fault);
      check("t8_ones", g_ones, 11);
      check("t8_resp", g_resp, 1);
      check("t8_fault", g_fault, 0);
      check("scoreboard_drained", exp_q.size(), 0);

      repeat (3) tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
